load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
- Read-side counterpart of the store byte-enable/shift logic. It takes a load request from the MEM stage and issues a word-aligned read on the data bus, which may have variable latency.
- On return it extracts the addressed byte or halfword and sign- or zero-extends it to 32 bits.
- It stalls the pipeline while a read is outstanding and returns a one-cycle result strobe.

Parameters:
TIMEOUT_CYCLES, 255, WAIT cycles without bus_ack before the access is abandoned (1..65535).
CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  clock, all state changes on rising edge.
reset  input  1  synchronous active-high reset.
req_valid  input  1  load request present this cycle.
ld_type  input  3  000 none, 001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU; 110/111 treated as none.
addr  input  32  byte address of the load.
stall  output  1  hold the pipeline this cycle.
bus_rd_req  output  1  read request to the data bus (registered).
bus_addr  output  32  word-aligned read address {addr[31:2],2'b00} (registered).
bus_rdata  input  32  read word from the bus, valid when bus_ack=1.
bus_ack  input  1  read data valid strobe.
rdata_out  output  32  extended load result (registered).
rdata_valid  output  1  one-cycle strobe, rdata_out valid.
bus_err  output  1  one-cycle strobe coincident with rdata_valid on timeout.
misalign_err  output  1  one-cycle strobe coincident with rdata_valid on misaligned access (see Optional Feature).

Behaviour:
- Reset: clk domain only, synchronous active-high. State=IDLE, timeout counter=0, latched addr/type=0. All registered outputs 0: bus_rd_req, bus_addr, rdata_out, rdata_valid, bus_err, misalign_err.
- Reset mid-access drops bus_rd_req on the next edge. A bus_ack arriving afterwards is ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE, with req_valid=1 and a valid ld_type:
  - Latch addr[1:0] and ld_type.
  - Set bus_addr and bus_rd_req=1, clear the counter, go to WAIT.
- IDLE, otherwise: req_valid with type none is ignored, and bus_ack is ignored.
- WAIT:
  - bus_rd_req and bus_addr are held constant.
  - The counter increments each cycle without ack.
  - On bus_ack=1: capture the extended bus_rdata into rdata_out, clear bus_rd_req, go to DONE.
  - When the counter reaches TIMEOUT_CYCLES with no ack: rdata_out=0, clear bus_rd_req, go to DONE with bus_err pending.
  - If ack and timeout occur in the same cycle, ack wins (no error).
- DONE (exactly one cycle):
  - rdata_valid=1; bus_err=1 only if the access timed out.
  - Next state is IDLE. A new request is accepted only from IDLE, the cycle after DONE.
- stall (combinational) = (IDLE & req_valid & valid type) | WAIT. It is 0 in DONE, so the consuming stage advances in the rdata_valid cycle.
- req_valid is ignored outside IDLE.
- Minimum latency: request cycle → WAIT (1 cycle with immediate ack) → DONE. rdata_valid appears 2 cycles after the request edge.
- Extraction uses the latched a=addr[1:0]:
  - LW: whole word.
  - LH/LHU: a[1]=0 selects bits 15:0, a[1]=1 selects bits 31:16.
  - LB/LBU: selects byte a (a=0 → bits 7:0, a=3 → bits 31:24).
  - LH/LB replicate bit 15/7 of the selected field into the upper bits; LHU/LBU zero-fill.
- Without the optional feature, a[0] is ignored for halfwords and a[1:0] is ignored for LW.

Optional Feature:
- Macro LOAD_MISALIGN_CHECK_EN.
- When defined, LW with addr[1:0]≠00 or LH/LHU with addr[0]=1 is misaligned:
  - No bus request is issued; IDLE goes directly to DONE.
  - stall=1 in the request cycle.
  - In DONE: rdata_out=0, rdata_valid=1, misalign_err=1.
- When undefined, misalign_err is tied to 0 and no check is made.

Test Plan:
- LW addr=0x104, bus_rdata=0xDEADBEEF, ack 1 cycle after req → rdata_out=0xDEADBEEF, bus_addr=0x104, rdata_valid at request edge+2, stall high exactly 2 cycles.
- LB addr=0x203, bus_rdata=0x80FF1234, ack after 3 wait cycles → rdata_out=0xFFFFFF80. Same access as LBU → 0x00000080. stall high for all wait cycles.
- LH addr=0x2, bus_rdata=0x8001_7FFF → 0xFFFF8001. LHU addr=0x0 same data → 0x00007FFF.
- No ack with TIMEOUT_CYCLES=4 → bus_rd_req drops after 4 WAIT cycles; rdata_out=0, rdata_valid=1, bus_err=1. Later stray ack ignored; next LW completes normally.
- reset asserted in WAIT → bus_rd_req=0 and state IDLE next edge; ack in following cycle produces no rdata_valid.
- With LOAD_MISALIGN_CHECK_EN: LW addr=0x101 → no bus_rd_req, rdata_valid=1 and misalign_err=1 one cycle after the request, rdata_out=0. Without the macro the same request reads word 0x100.

Source files
------------

// File: rtl/load_align_unit.sv
// Load path: issues a word-aligned bus read, waits for a variable-latency ack, and
// extracts and extends a byte/halfword/word. Optional check: LOAD_MISALIGN_CHECK_EN.
module load_align_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  ld_type,
  input  logic [31:0] addr,
  output logic        stall,
  output logic        bus_rd_req,
  output logic [31:0] bus_addr,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        bus_err,
  output logic        misalign_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] LD_LW  = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LB  = 3'b100;
  localparam logic [2:0] LD_LBU = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       off_q, off_d;
  logic [2:0]       type_q, type_d;
  logic             bus_rd_req_q, bus_rd_req_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rdata_valid_q, rdata_valid_d;
  logic             bus_err_q, bus_err_d;
  logic             misalign_err_q, misalign_err_d;

  logic        type_valid;
  logic        misaligned;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] ext_data;

  assign type_valid = (ld_type != 3'b000) && (ld_type <= LD_LBU);
  assign cnt_inc    = cnt_q + CNT_W'(1);

`ifdef LOAD_MISALIGN_CHECK_EN
  assign misaligned = ((ld_type == LD_LW) && (addr[1:0] != 2'b00)) ||
                      (((ld_type == LD_LH) || (ld_type == LD_LHU)) && addr[0]);
`else
  assign misaligned = 1'b0;
`endif

  // Field selection uses the offset latched at request time, not the live address.
  always_comb begin
    half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (off_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    case (type_q)
      LD_LW:   ext_data = bus_rdata;
      LD_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  ext_data = {16'h0000, half_sel};
      LD_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  ext_data = {24'h000000, byte_sel};
      default: ext_data = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    off_d          = off_q;
    type_d         = type_q;
    bus_rd_req_d   = bus_rd_req_q;
    bus_addr_d     = bus_addr_q;
    rdata_d        = rdata_q;
    rdata_valid_d  = 1'b0;
    bus_err_d      = 1'b0;
    misalign_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && type_valid) begin
          off_d  = addr[1:0];
          type_d = ld_type;
          cnt_d  = '0;
          if (misaligned) begin
            rdata_d        = 32'h0000_0000;
            rdata_valid_d  = 1'b1;
            misalign_err_d = 1'b1;
            state_d        = DONE;
          end else begin
            bus_addr_d   = {addr[31:2], 2'b00};
            bus_rd_req_d = 1'b1;
            state_d      = WAIT;
          end
        end
      end
      WAIT: begin
        // An ack in the timeout cycle still delivers data without an error.
        if (bus_ack) begin
          rdata_d       = ext_data;
          bus_rd_req_d  = 1'b0;
          rdata_valid_d = 1'b1;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
            rdata_d       = 32'h0000_0000;
            bus_rd_req_d  = 1'b0;
            rdata_valid_d = 1'b1;
            bus_err_d     = 1'b1;
            state_d       = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      off_q          <= 2'b00;
      type_q         <= 3'b000;
      bus_rd_req_q   <= 1'b0;
      bus_addr_q     <= 32'h0000_0000;
      rdata_q        <= 32'h0000_0000;
      rdata_valid_q  <= 1'b0;
      bus_err_q      <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      off_q          <= off_d;
      type_q         <= type_d;
      bus_rd_req_q   <= bus_rd_req_d;
      bus_addr_q     <= bus_addr_d;
      rdata_q        <= rdata_d;
      rdata_valid_q  <= rdata_valid_d;
      bus_err_q      <= bus_err_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign stall        = ((state_q == IDLE) && req_valid && type_valid) || (state_q == WAIT);
  assign bus_rd_req   = bus_rd_req_q;
  assign bus_addr     = bus_addr_q;
  assign rdata_out    = rdata_q;
  assign rdata_valid  = rdata_valid_q;
  assign bus_err      = bus_err_q;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: stimulus pushes expected results, a monitor
// pops them on every rdata_valid strobe. Honours LOAD_MISALIGN_CHECK_EN.
module tb_load_align_unit;

  localparam int TMO = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [2:0]  ld_type;
  logic [31:0] addr;
  logic        stall;
  logic        bus_rd_req;
  logic [31:0] bus_addr;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        bus_err;
  logic        misalign_err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  load_align_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .ld_type      (ld_type),
    .addr         (addr),
    .stall        (stall),
    .bus_rd_req   (bus_rd_req),
    .bus_addr     (bus_addr),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .rdata_out    (rdata_out),
    .rdata_valid  (rdata_valid),
    .bus_err      (bus_err),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fails++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, required);
    end
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rdata_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_rdata_valid: actual rdata_out 0x%08h required no strobe", rdata_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_rdata_out", rdata_out, e.data);
        checkOutput("sb_bus_err", {31'd0, bus_err}, {31'd0, e.err});
        checkOutput("sb_misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One load transaction; ack_delay = WAIT cycles without ack before the ack cycle, -1 = never.
  task automatic applyStimulus(input logic [2:0] t, input logic [31:0] a, input logic [31:0] word,
                               input int ack_delay, input logic [31:0] exp_data,
                               input logic exp_err, input logic [31:0] exp_addr);
    int n_wait;
    exp_t e;
    n_wait = (ack_delay < 0) ? TMO : ack_delay + 1;
    step();
    req_valid = 1'b1;
    ld_type   = t;
    addr      = a;
    #1;
    checkOutput("stall_request_cycle", {31'd0, stall}, 32'd1);
    e.data = exp_data;
    e.err  = exp_err;
    e.mis  = 1'b0;
    sb.push_back(e);
    step();
    req_valid = 1'b0;
    ld_type   = 3'b000;
    addr      = 32'h0;
    for (int i = 0; i < n_wait; i++) begin
      #1;
      checkOutput("bus_rd_req_wait", {31'd0, bus_rd_req}, 32'd1);
      checkOutput("bus_addr_wait", bus_addr, exp_addr);
      checkOutput("stall_wait", {31'd0, stall}, 32'd1);
      if (i == ack_delay) begin
        bus_ack   = 1'b1;
        bus_rdata = word;
      end
      step();
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
    end
    #1;
    checkOutput("rdata_valid_done", {31'd0, rdata_valid}, 32'd1);
    checkOutput("stall_done", {31'd0, stall}, 32'd0);
    checkOutput("bus_rd_req_done", {31'd0, bus_rd_req}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    ld_type   = 3'b000;
    addr      = 32'h0;
    bus_rdata = 32'h0;
    bus_ack   = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    checkOutput("reset_bus_rd_req", {31'd0, bus_rd_req}, 32'd0);
    checkOutput("reset_bus_addr", bus_addr, 32'h0);
    checkOutput("reset_rdata_out", rdata_out, 32'h0);
    checkOutput("reset_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    checkOutput("reset_bus_err", {31'd0, bus_err}, 32'd0);
    checkOutput("reset_misalign_err", {31'd0, misalign_err}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);

    // Requests of type none are ignored.
    req_valid = 1'b1;
    ld_type   = 3'b000;
    addr      = 32'h40;
    #1;
    checkOutput("stall_type_none", {31'd0, stall}, 32'd0);
    step();
    ld_type = 3'b110;
    #1;
    checkOutput("stall_type_110", {31'd0, stall}, 32'd0);
    checkOutput("no_req_type_none", {31'd0, bus_rd_req}, 32'd0);
    step();
    req_valid = 1'b0;
    ld_type   = 3'b000;
    checkOutput("no_req_type_110", {31'd0, bus_rd_req}, 32'd0);

    applyStimulus(3'b001, 32'h104, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 32'h104);
    applyStimulus(3'b100, 32'h203, 32'h80FF1234, 3, 32'hFFFFFF80, 1'b0, 32'h200);
    applyStimulus(3'b101, 32'h203, 32'h80FF1234, 3, 32'h00000080, 1'b0, 32'h200);
    applyStimulus(3'b100, 32'h201, 32'h80FF1234, 1, 32'h00000012, 1'b0, 32'h200);
    applyStimulus(3'b010, 32'h002, 32'h80017FFF, 0, 32'hFFFF8001, 1'b0, 32'h000);
    applyStimulus(3'b011, 32'h000, 32'h80017FFF, 2, 32'h00007FFF, 1'b0, 32'h000);
    applyStimulus(3'b011, 32'h002, 32'h80017FFF, 0, 32'h00008001, 1'b0, 32'h000);

    // Timeout, then a stray ack in IDLE, then a normal load.
    applyStimulus(3'b001, 32'h400, 32'h0, -1, 32'h0, 1'b1, 32'h400);
    step();
    bus_ack   = 1'b1;
    bus_rdata = 32'h12345678;
    step();
    bus_ack   = 1'b0;
    #1;
    checkOutput("stray_ack_no_valid", {31'd0, rdata_valid}, 32'd0);
    checkOutput("stray_ack_no_req", {31'd0, bus_rd_req}, 32'd0);
    applyStimulus(3'b001, 32'h408, 32'hA5A5_0F0F, 1, 32'hA5A5_0F0F, 1'b0, 32'h408);

    // Reset in WAIT abandons the access; a late ack must not produce a result.
    step();
    req_valid = 1'b1;
    ld_type   = 3'b001;
    addr      = 32'h300;
    step();
    req_valid = 1'b0;
    ld_type   = 3'b000;
    #1;
    checkOutput("reset_case_in_wait", {31'd0, bus_rd_req}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checkOutput("reset_mid_drops_req", {31'd0, bus_rd_req}, 32'd0);
    checkOutput("reset_mid_stall", {31'd0, stall}, 32'd0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h77777777;
    step();
    bus_ack = 1'b0;
    #1;
    checkOutput("late_ack_no_valid", {31'd0, rdata_valid}, 32'd0);
    step();
    #1;
    checkOutput("late_ack_no_valid2", {31'd0, rdata_valid}, 32'd0);

`ifdef LOAD_MISALIGN_CHECK_EN
    begin
      exp_t e;
      step();
      req_valid = 1'b1;
      ld_type   = 3'b001;
      addr      = 32'h101;
      #1;
      checkOutput("misalign_stall", {31'd0, stall}, 32'd1);
      e.data = 32'h0;
      e.err  = 1'b0;
      e.mis  = 1'b1;
      sb.push_back(e);
      step();
      req_valid = 1'b0;
      ld_type   = 3'b000;
      #1;
      checkOutput("misalign_no_req", {31'd0, bus_rd_req}, 32'd0);
      checkOutput("misalign_valid", {31'd0, rdata_valid}, 32'd1);
      checkOutput("misalign_stall_done", {31'd0, stall}, 32'd0);
    end
`else
    applyStimulus(3'b001, 32'h101, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b0, 32'h100);
    applyStimulus(3'b011, 32'h003, 32'h80017FFF, 0, 32'h00008001, 1'b0, 32'h000);
`endif

    repeat (3) step();
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
